// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
// The DATA_W/FID_W-sized commit fields are wrapped around cmt_flags_t inside the users.
package rob_pkg;

   localparam int unsigned CMTDELAY_W = 4;
   localparam int unsigned DST_W      = 5;

   typedef struct packed {
      logic [DST_W-1:0] dst;
      logic             load;
      logic             store;
      logic             lsmiss;
      logic [1:0]       lswidth;
      logic             bco_valid;
      logic             bco_taken;
      logic [1:0]       bco_pattern;
   } cmt_flags_t;

   // Per-entry commit delay counts down and sticks at zero.
   function automatic logic [CMTDELAY_W-1:0] dec_sat(input logic [CMTDELAY_W-1:0] v);
      return (v == '0) ? v : v - 1'b1;
   endfunction

endpackage

// File: rtl/rob_param_core_if.sv
// Allocation, writeback, operand-read and commit signals of the reorder buffer.
// The master modport is the pipeline side; the slave modport is the buffer.
interface rob_param_core_if
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FID_W  = 8,
   parameter int unsigned NREAD  = 2
);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic                    alloc_valid;
   logic                    alloc_ready;
   logic [DATA_W-1:0]       alloc_pc;
   logic [DST_W-1:0]        alloc_dst;
   logic [FID_W-1:0]        alloc_fid;
   logic                    alloc_load;
   logic                    alloc_store;
   logic [1:0]              alloc_lswidth;
   logic [IDX_W:0]          alloc_idx;

   logic                    wb_valid;
   logic [IDX_W-1:0]        wb_idx;
   logic [FID_W-1:0]        wb_fid;
   logic [DATA_W-1:0]       wb_value;
   logic                    wb_lsmiss;
   logic [CMTDELAY_W-1:0]   wb_cmtdelay;
   logic                    wb_bco_valid;
   logic                    wb_bco_taken;
   logic [1:0]              wb_bco_pattern;
   logic [DATA_W-1:0]       wb_bco_target;

   logic [NREAD*IDX_W-1:0]  rd_idx;
   logic [NREAD*DATA_W-1:0] rd_data;
   logic [NREAD-1:0]        rd_ready;

   logic                    cmt_valid;
   logic                    cmt_accept;
   logic [IDX_W-1:0]        cmt_idx;
   logic [DATA_W-1:0]       cmt_pc;
   logic [DATA_W-1:0]       cmt_value;
   logic [DATA_W-1:0]       cmt_bco_target;
   logic [DST_W-1:0]        cmt_dst;
   logic [FID_W-1:0]        cmt_fid;
   logic                    cmt_load;
   logic                    cmt_store;
   logic                    cmt_lsmiss;
   logic                    cmt_bco_valid;
   logic                    cmt_bco_taken;
   logic [1:0]              cmt_lswidth;
   logic [1:0]              cmt_bco_pattern;

   logic [IDX_W:0]          count;

   modport master (
      output alloc_valid, alloc_pc, alloc_dst, alloc_fid, alloc_load, alloc_store, alloc_lswidth,
      input  alloc_ready, alloc_idx,
      output wb_valid, wb_idx, wb_fid, wb_value, wb_lsmiss, wb_cmtdelay,
      output wb_bco_valid, wb_bco_taken, wb_bco_pattern, wb_bco_target,
      output rd_idx,
      input  rd_data, rd_ready,
      output cmt_accept,
      input  cmt_valid, cmt_idx, cmt_pc, cmt_value, cmt_bco_target, cmt_dst, cmt_fid,
      input  cmt_load, cmt_store, cmt_lsmiss, cmt_bco_valid, cmt_bco_taken,
      input  cmt_lswidth, cmt_bco_pattern,
      input  count
   );

   modport slave (
      input  alloc_valid, alloc_pc, alloc_dst, alloc_fid, alloc_load, alloc_store, alloc_lswidth,
      output alloc_ready, alloc_idx,
      input  wb_valid, wb_idx, wb_fid, wb_value, wb_lsmiss, wb_cmtdelay,
      input  wb_bco_valid, wb_bco_taken, wb_bco_pattern, wb_bco_target,
      input  rd_idx,
      output rd_data, rd_ready,
      input  cmt_accept,
      output cmt_valid, cmt_idx, cmt_pc, cmt_value, cmt_bco_target, cmt_dst, cmt_fid,
      output cmt_load, cmt_store, cmt_lsmiss, cmt_bco_valid, cmt_bco_taken,
      output cmt_lswidth, cmt_bco_pattern,
      output count
   );

endinterface

// File: rtl/rob_cmt_stage.sv
// Registered valid/accept output stage: loads a new payload whenever it is empty or
// being accepted, otherwise holds its contents stable.
module rob_cmt_stage #(
   parameter type payload_t = logic
) (
   input  logic     clk_i,
   input  logic     resetn_i,
   input  logic     flush_i,
   input  logic     head_ok_i,
   input  payload_t head_i,
   input  logic     accept_i,
   output logic     take_o,
   output logic     retire_o,
   output logic     valid_o,
   output payload_t data_o
);

   logic     valid_q, valid_d;
   payload_t data_q, data_d;
   logic     adv;

   always_comb begin
      adv     = ~valid_q | accept_i;
      valid_d = valid_q;
      data_d  = data_q;
      take_o  = 1'b0;
      if (adv) begin
         valid_d = head_ok_i;
         if (head_ok_i) begin
            data_d = head_i;
            take_o = 1'b1;
         end
      end
      if (flush_i) begin
         valid_d = 1'b0;
      end
   end

   assign retire_o = valid_q & accept_i;
   assign valid_o  = valid_q;
   assign data_o   = data_q;

   always_ff @(posedge clk_i) begin
      if (!resetn_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   // Payload is only meaningful while valid_q is set, so it needs no reset.
   always_ff @(posedge clk_i) begin
      data_q <= data_d;
   end

endmodule

// File: rtl/rob_param_core.sv
// Parametrised reorder buffer: in-order allocation, fid-qualified out-of-order writeback,
// N operand read ports and a registered valid/accept commit stage.
module rob_param_core
   import rob_pkg::*;
#(
   parameter int unsigned DEPTH  = 16,
   parameter int unsigned DATA_W = 32,
   parameter int unsigned FID_W  = 8,
   parameter int unsigned NREAD  = 2
) (
   input logic              clk,
   input logic              resetn,
   input logic              flush,
   rob_param_core_if.slave  bus
);

   localparam int unsigned IDX_W = $clog2(DEPTH);
   localparam int unsigned PTR_W = IDX_W + 1;

   typedef struct packed {
      logic [DATA_W-1:0] pc;
      logic [DST_W-1:0]  dst;
      logic [FID_W-1:0]  fid;
      logic              load;
      logic              store;
      logic [1:0]        lswidth;
   } alloc_ent_t;

   typedef struct packed {
      logic [DATA_W-1:0] value;
      logic              lsmiss;
      logic              bco_valid;
      logic              bco_taken;
      logic [1:0]        bco_pattern;
      logic [DATA_W-1:0] bco_target;
   } wb_ent_t;

   typedef struct packed {
      logic [IDX_W-1:0]  idx;
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] value;
      logic [DATA_W-1:0] bco_target;
      logic [FID_W-1:0]  fid;
      cmt_flags_t        flags;
   } payload_t;

   logic [PTR_W-1:0] wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
   logic [DEPTH-1:0] ready_q, ready_d;
   logic [DEPTH-1:0][CMTDELAY_W-1:0] cmtdelay_q, cmtdelay_d;
   alloc_ent_t [DEPTH-1:0] ent_q, ent_d;
   wb_ent_t [DEPTH-1:0]    wbf_q, wbf_d;

   logic [IDX_W-1:0] waddr, cidx;
   logic full, cempty, alloc_fire, wb_fire, head_ok, take, retire, cmt_valid;
   payload_t head, cmt;

   assign waddr      = wptr_q[IDX_W-1:0];
   assign cidx       = cptr_q[IDX_W-1:0];
   // Same slot with opposite lap bits means the writer has lapped the retire pointer.
   assign full       = (wptr_q[IDX_W] != rptr_q[IDX_W]) && (waddr == rptr_q[IDX_W-1:0]);
   assign cempty     = (wptr_q == cptr_q);
   assign alloc_fire = bus.alloc_valid & ~full;
   assign wb_fire    = bus.wb_valid & (ent_q[bus.wb_idx].fid == bus.wb_fid);
   assign head_ok    = ~cempty & ready_q[cidx] & (cmtdelay_q[cidx] == '0);

   always_comb begin
      ent_d   = ent_q;
      wbf_d   = wbf_q;
      ready_d = ready_q;
      for (int i = 0; i < int'(DEPTH); i++) begin
         cmtdelay_d[IDX_W'(i)] = dec_sat(cmtdelay_q[IDX_W'(i)]);
      end
      if (wb_fire) begin
         wbf_d[bus.wb_idx].value       = bus.wb_value;
         wbf_d[bus.wb_idx].lsmiss      = bus.wb_lsmiss;
         wbf_d[bus.wb_idx].bco_valid   = bus.wb_bco_valid;
         wbf_d[bus.wb_idx].bco_taken   = bus.wb_bco_taken;
         wbf_d[bus.wb_idx].bco_pattern = bus.wb_bco_pattern;
         wbf_d[bus.wb_idx].bco_target  = bus.wb_bco_target;
         ready_d[bus.wb_idx]           = 1'b1;
         cmtdelay_d[bus.wb_idx]        = bus.wb_cmtdelay;
      end
      // Applied after writeback so a same-slot allocation leaves the entry not ready.
      if (alloc_fire) begin
         ent_d[waddr].pc      = bus.alloc_pc;
         ent_d[waddr].dst     = bus.alloc_dst;
         ent_d[waddr].fid     = bus.alloc_fid;
         ent_d[waddr].load    = bus.alloc_load;
         ent_d[waddr].store   = bus.alloc_store;
         ent_d[waddr].lswidth = bus.alloc_lswidth;
         ready_d[waddr]       = 1'b0;
      end
   end

   always_comb begin
      wptr_d = wptr_q + {{IDX_W{1'b0}}, alloc_fire};
      cptr_d = cptr_q + {{IDX_W{1'b0}}, take};
      rptr_d = rptr_q + {{IDX_W{1'b0}}, retire};
      if (flush) begin
         wptr_d = '0;
         cptr_d = '0;
         rptr_d = '0;
      end
   end

   always_comb begin
      head                   = '0;
      head.idx               = cidx;
      head.pc                = ent_q[cidx].pc;
      head.value             = wbf_q[cidx].value;
      head.bco_target        = wbf_q[cidx].bco_target;
      head.fid               = ent_q[cidx].fid;
      head.flags.dst         = ent_q[cidx].dst;
      head.flags.load        = ent_q[cidx].load;
      head.flags.store       = ent_q[cidx].store;
      head.flags.lsmiss      = wbf_q[cidx].lsmiss;
      head.flags.lswidth     = ent_q[cidx].lswidth;
      head.flags.bco_valid   = wbf_q[cidx].bco_valid;
      head.flags.bco_taken   = wbf_q[cidx].bco_taken;
      head.flags.bco_pattern = wbf_q[cidx].bco_pattern;
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wptr_q     <= '0;
         cptr_q     <= '0;
         rptr_q     <= '0;
         ready_q    <= '0;
         cmtdelay_q <= '0;
      end else begin
         wptr_q     <= wptr_d;
         cptr_q     <= cptr_d;
         rptr_q     <= rptr_d;
         ready_q    <= ready_d;
         cmtdelay_q <= cmtdelay_d;
      end
   end

   always_ff @(posedge clk) begin
      ent_q <= ent_d;
      wbf_q <= wbf_d;
   end

   rob_cmt_stage #(
      .payload_t (payload_t)
   ) u_cmt_stage (
      .clk_i     (clk),
      .resetn_i  (resetn),
      .flush_i   (flush),
      .head_ok_i (head_ok),
      .head_i    (head),
      .accept_i  (bus.cmt_accept),
      .take_o    (take),
      .retire_o  (retire),
      .valid_o   (cmt_valid),
      .data_o    (cmt)
   );

   // Operand reads see registered state only; a same-cycle writeback is not bypassed.
   for (genvar k = 0; k < int'(NREAD); k++) begin : g_rd
      logic [IDX_W-1:0] ridx;
      assign ridx = bus.rd_idx[k*IDX_W +: IDX_W];
      assign bus.rd_data[k*DATA_W +: DATA_W] = wbf_q[ridx].value;
      assign bus.rd_ready[k] = ready_q[ridx] & ~wbf_q[ridx].lsmiss;
   end

   assign bus.alloc_ready     = ~full;
   assign bus.alloc_idx       = wptr_q;
   assign bus.count           = wptr_q - rptr_q;
   assign bus.cmt_valid       = cmt_valid;
   assign bus.cmt_idx         = cmt.idx;
   assign bus.cmt_pc          = cmt.pc;
   assign bus.cmt_value       = cmt.value;
   assign bus.cmt_bco_target  = cmt.bco_target;
   assign bus.cmt_fid         = cmt.fid;
   assign bus.cmt_dst         = cmt.flags.dst;
   assign bus.cmt_load        = cmt.flags.load;
   assign bus.cmt_store       = cmt.flags.store;
   assign bus.cmt_lsmiss      = cmt.flags.lsmiss;
   assign bus.cmt_lswidth     = cmt.flags.lswidth;
   assign bus.cmt_bco_valid   = cmt.flags.bco_valid;
   assign bus.cmt_bco_taken   = cmt.flags.bco_taken;
   assign bus.cmt_bco_pattern = cmt.flags.bco_pattern;

endmodule

// File: tb/tb_rob_param_core.sv
// Directed bench for rob_param_core: a cycle table for allocate/writeback/commit/read,
// then hand sequences for full, commit delay, hold, wrap-around and flush.
module tb_rob_param_core;

   localparam int unsigned DEPTH  = 16;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned FID_W  = 8;
   localparam int unsigned NREAD  = 2;

   logic clk;
   logic resetn;
   logic flush;

   int checks;
   int errors;
   int m_count;
   int m_widx;
   int next_cmt;
   logic [31:0] exp_val [16];

   rob_param_core_if #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .FID_W  (FID_W),
      .NREAD  (NREAD)
   ) bus ();

   rob_param_core #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .FID_W  (FID_W),
      .NREAD  (NREAD)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .flush  (flush),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        alloc;
      logic [7:0]  fid;
      logic        wb;
      logic [3:0]  wb_idx;
      logic [7:0]  wb_fid;
      logic [31:0] wb_value;
      logic        wb_lsmiss;
      logic        accept;
      logic [4:0]  e_count;
      logic        e_cv;
      logic [3:0]  e_cidx;
      logic [31:0] e_cval;
      logic [1:0]  e_rdy;
      logic        chk_rd;
   } vec_t;

   vec_t vt [15];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_in();
      bus.alloc_valid    = 1'b0;
      bus.alloc_pc       = '0;
      bus.alloc_dst      = '0;
      bus.alloc_fid      = '0;
      bus.alloc_load     = 1'b0;
      bus.alloc_store    = 1'b0;
      bus.alloc_lswidth  = '0;
      bus.wb_valid       = 1'b0;
      bus.wb_idx         = '0;
      bus.wb_fid         = '0;
      bus.wb_value       = '0;
      bus.wb_lsmiss      = 1'b0;
      bus.wb_cmtdelay    = '0;
      bus.wb_bco_valid   = 1'b0;
      bus.wb_bco_taken   = 1'b0;
      bus.wb_bco_pattern = '0;
      bus.wb_bco_target  = '0;
      bus.rd_idx         = {4'd1, 4'd3};
   endtask

   task automatic do_reset();
      clr_in();
      bus.cmt_accept = 1'b0;
      flush  = 1'b0;
      resetn = 1'b0;
      step();
      step();
      resetn   = 1'b1;
      m_count  = 0;
      m_widx   = 0;
      next_cmt = 0;
   endtask

   task automatic do_alloc(input logic [7:0] fid);
      bus.alloc_valid = 1'b1;
      bus.alloc_fid   = fid;
      bus.alloc_pc    = {24'h0, fid};
      bus.alloc_dst   = fid[4:0];
      if (m_count < int'(DEPTH)) begin
         m_count++;
         m_widx = (m_widx + 1) % 32;
      end
      step();
      bus.alloc_valid = 1'b0;
      chk("alloc_count", 64'(bus.count), 64'(m_count));
      chk("alloc_idx", 64'(bus.alloc_idx), 64'(m_widx));
   endtask

   task automatic do_wb(input logic [3:0] idx, input logic [7:0] fid, input logic [31:0] val,
                        input logic [3:0] dly, input logic miss);
      bus.wb_valid    = 1'b1;
      bus.wb_idx      = idx;
      bus.wb_fid      = fid;
      bus.wb_value    = val;
      bus.wb_cmtdelay = dly;
      bus.wb_lsmiss   = miss;
      step();
      bus.wb_valid = 1'b0;
   endtask

   task automatic drain(input int n);
      int got;
      got = 0;
      bus.cmt_accept = 1'b1;
      for (int c = 0; c < n * 4 + 8 && got < n; c++) begin
         if (bus.cmt_valid) begin
            chk("drain_idx", 64'(bus.cmt_idx), 64'(next_cmt % 16));
            chk("drain_value", 64'(bus.cmt_value), 64'(exp_val[next_cmt % 16]));
            next_cmt++;
            got++;
            m_count--;
         end
         step();
         chk("drain_count", 64'(bus.count), 64'(m_count));
      end
      bus.cmt_accept = 1'b0;
      chk("drain_done", 64'(got), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;

      vt[0]  = '{1'b1, 8'h20, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b0, 5'd1, 1'b0, 4'd0, 32'h0,
                 2'b00, 1'b0};
      vt[1]  = '{1'b1, 8'h21, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b0, 5'd2, 1'b0, 4'd0, 32'h0,
                 2'b00, 1'b0};
      vt[2]  = '{1'b1, 8'h22, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b0, 5'd3, 1'b0, 4'd0, 32'h0,
                 2'b00, 1'b0};
      vt[3]  = '{1'b1, 8'h12, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b0, 5'd4, 1'b0, 4'd0, 32'h0,
                 2'b00, 1'b0};
      vt[4]  = '{1'b0, 8'h00, 1'b1, 4'd3, 8'h13, 32'h11111111, 1'b0, 1'b0, 5'd4, 1'b0, 4'd0,
                 32'h0, 2'b00, 1'b0};
      vt[5]  = '{1'b0, 8'h00, 1'b1, 4'd3, 8'h12, 32'hDEADBEEF, 1'b0, 1'b0, 5'd4, 1'b0, 4'd0,
                 32'h0, 2'b01, 1'b0};
      vt[6]  = '{1'b0, 8'h00, 1'b1, 4'd1, 8'h21, 32'h00001111, 1'b1, 1'b0, 5'd4, 1'b0, 4'd0,
                 32'h0, 2'b01, 1'b1};
      vt[7]  = '{1'b0, 8'h00, 1'b1, 4'd0, 8'h20, 32'h000000A0, 1'b0, 1'b0, 5'd4, 1'b0, 4'd0,
                 32'h0, 2'b01, 1'b1};
      vt[8]  = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b0, 5'd4, 1'b1, 4'd0,
                 32'h000000A0, 2'b01, 1'b1};
      vt[9]  = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b1, 5'd3, 1'b1, 4'd1,
                 32'h00001111, 2'b01, 1'b1};
      vt[10] = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b1, 5'd2, 1'b0, 4'd0, 32'h0,
                 2'b01, 1'b1};
      vt[11] = '{1'b0, 8'h00, 1'b1, 4'd2, 8'h22, 32'h00002222, 1'b0, 1'b0, 5'd2, 1'b0, 4'd0,
                 32'h0, 2'b01, 1'b1};
      vt[12] = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b0, 5'd2, 1'b1, 4'd2,
                 32'h00002222, 2'b01, 1'b1};
      vt[13] = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b1, 5'd1, 1'b1, 4'd3,
                 32'hDEADBEEF, 2'b01, 1'b1};
      vt[14] = '{1'b0, 8'h00, 1'b0, 4'd0, 8'h00, 32'h0, 1'b0, 1'b1, 5'd0, 1'b0, 4'd0, 32'h0,
                 2'b01, 1'b1};

      // Reset state
      do_reset();
      chk("rst_count", 64'(bus.count), 64'(0));
      chk("rst_alloc_ready", 64'(bus.alloc_ready), 64'(1));
      chk("rst_cmt_valid", 64'(bus.cmt_valid), 64'(0));
      chk("rst_alloc_idx", 64'(bus.alloc_idx), 64'(0));
      chk("rst_rd_ready", 64'(bus.rd_ready), 64'(0));

      // Cycle table: fid-qualified writeback, read ports, commit handshake
      for (int i = 0; i < 15; i++) begin
         bus.alloc_valid = vt[i].alloc;
         bus.alloc_fid   = vt[i].fid;
         bus.wb_valid    = vt[i].wb;
         bus.wb_idx      = vt[i].wb_idx;
         bus.wb_fid      = vt[i].wb_fid;
         bus.wb_value    = vt[i].wb_value;
         bus.wb_lsmiss   = vt[i].wb_lsmiss;
         bus.wb_cmtdelay = 4'd0;
         bus.cmt_accept  = vt[i].accept;
         step();
         chk($sformatf("tbl%0d_count", i), 64'(bus.count), 64'(vt[i].e_count));
         chk($sformatf("tbl%0d_cmt_valid", i), 64'(bus.cmt_valid), 64'(vt[i].e_cv));
         chk($sformatf("tbl%0d_rd_ready", i), 64'(bus.rd_ready), 64'(vt[i].e_rdy));
         if (vt[i].e_cv) begin
            chk($sformatf("tbl%0d_cmt_idx", i), 64'(bus.cmt_idx), 64'(vt[i].e_cidx));
            chk($sformatf("tbl%0d_cmt_value", i), 64'(bus.cmt_value), 64'(vt[i].e_cval));
         end
         if (vt[i].chk_rd) begin
            chk($sformatf("tbl%0d_rd_data", i), 64'(bus.rd_data), {32'h00001111, 32'hDEADBEEF});
         end
      end
      clr_in();
      bus.cmt_accept = 1'b0;

      // Full: 16 allocations, 17th ignored, accept frees a slot one cycle later
      do_reset();
      for (int i = 0; i < 16; i++) do_alloc(8'(i));
      chk("full_alloc_ready", 64'(bus.alloc_ready), 64'(0));
      chk("full_count", 64'(bus.count), 64'(16));
      do_alloc(8'hEE);
      chk("full_17_count", 64'(bus.count), 64'(16));
      chk("full_17_alloc_idx", 64'(bus.alloc_idx), 64'(16));
      do_wb(4'd0, 8'h00, 32'h55, 4'd0, 1'b0);
      step();
      chk("full_cmt_valid", 64'(bus.cmt_valid), 64'(1));
      chk("full_cmt_fid", 64'(bus.cmt_fid), 64'(0));
      bus.cmt_accept = 1'b1;
      chk("full_ready_during_accept", 64'(bus.alloc_ready), 64'(0));
      step();
      bus.cmt_accept = 1'b0;
      chk("full_ready_after_accept", 64'(bus.alloc_ready), 64'(1));
      chk("full_count_after_accept", 64'(bus.count), 64'(15));

      // Commit delay of 3: presented 4 edges after the writeback edge
      do_reset();
      do_alloc(8'h05);
      do_wb(4'd0, 8'h05, 32'h0000CAFE, 4'd3, 1'b0);
      chk("dly_cv_k0", 64'(bus.cmt_valid), 64'(0));
      for (int k = 1; k <= 4; k++) begin
         step();
         chk($sformatf("dly_cv_k%0d", k), 64'(bus.cmt_valid), 64'(k == 4));
      end
      chk("dly_value", 64'(bus.cmt_value), 64'(32'h0000CAFE));
      chk("dly_pc", 64'(bus.cmt_pc), 64'(32'h5));
      chk("dly_dst", 64'(bus.cmt_dst), 64'(5));

      // Hold while not accepted, then back-to-back presentation
      do_alloc(8'h06);
      do_alloc(8'h07);
      do_wb(4'd1, 8'h06, 32'h000000B1, 4'd0, 1'b0);
      do_wb(4'd2, 8'h07, 32'h000000B2, 4'd0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         step();
         chk("hold_valid", 64'(bus.cmt_valid), 64'(1));
         chk("hold_idx", 64'(bus.cmt_idx), 64'(0));
         chk("hold_value", 64'(bus.cmt_value), 64'(32'h0000CAFE));
      end
      bus.cmt_accept = 1'b1;
      step();
      chk("b2b_idx1", 64'(bus.cmt_idx), 64'(1));
      chk("b2b_value1", 64'(bus.cmt_value), 64'(32'hB1));
      chk("b2b_valid1", 64'(bus.cmt_valid), 64'(1));
      step();
      chk("b2b_idx2", 64'(bus.cmt_idx), 64'(2));
      chk("b2b_value2", 64'(bus.cmt_value), 64'(32'hB2));
      step();
      bus.cmt_accept = 1'b0;
      chk("b2b_empty", 64'(bus.cmt_valid), 64'(0));
      chk("b2b_count", 64'(bus.count), 64'(0));

      // Wrap: 10 allocated, 8 retired, 12 more allocated across the end of the array
      do_reset();
      for (int i = 0; i < 10; i++) do_alloc(8'(i));
      for (int i = 0; i < 10; i++) begin
         exp_val[i] = 32'h100 + 32'(i);
         do_wb(4'(i), 8'(i), exp_val[i], 4'd0, 1'b0);
      end
      drain(8);
      for (int k = 0; k < 12; k++) begin
         int idx;
         idx = (10 + k) % 16;
         do_alloc(8'(8'h40 + idx));
      end
      chk("wrap_alloc_idx", 64'(bus.alloc_idx), 64'(22));
      for (int k = 0; k < 12; k++) begin
         int idx;
         idx = (10 + k) % 16;
         exp_val[idx] = 32'h200 + 32'(k);
         do_wb(4'(idx), 8'(8'h40 + idx), exp_val[idx], 4'd0, 1'b0);
      end
      drain(14);

      // Flush with a presented entry and 5 pending, then reuse from index 0
      for (int k = 0; k < 5; k++) do_alloc(8'(8'h60 + 6 + k));
      for (int k = 0; k < 5; k++) do_wb(4'(6 + k), 8'(8'h60 + 6 + k), 32'h300, 4'd0, 1'b0);
      for (int c = 0; c < 8 && !bus.cmt_valid; c++) step();
      chk("fl_pre_cv", 64'(bus.cmt_valid), 64'(1));
      chk("fl_pre_count", 64'(bus.count), 64'(5));
      flush = 1'b1;
      bus.alloc_valid = 1'b1;
      step();
      flush = 1'b0;
      bus.alloc_valid = 1'b0;
      m_count  = 0;
      m_widx   = 0;
      next_cmt = 0;
      chk("fl_cv", 64'(bus.cmt_valid), 64'(0));
      chk("fl_count", 64'(bus.count), 64'(0));
      chk("fl_alloc_idx", 64'(bus.alloc_idx), 64'(0));
      do_alloc(8'h77);
      step();
      chk("fl_stale_cv", 64'(bus.cmt_valid), 64'(0));
      do_wb(4'd0, 8'h77, 32'h00007777, 4'd0, 1'b0);
      step();
      chk("fl_new_cv", 64'(bus.cmt_valid), 64'(1));
      chk("fl_new_idx", 64'(bus.cmt_idx), 64'(0));
      chk("fl_new_value", 64'(bus.cmt_value), 64'(32'h00007777));
      chk("fl_new_fid", 64'(bus.cmt_fid), 64'(8'h77));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
